// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch queue.
package fetch_pkg;

    localparam int          FQ_DEPTH       = 4;
    localparam logic [3:0]  FQ_HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        FQ_FETCH   = 2'd0,
        FQ_DISCARD = 2'd1,
        FQ_HALTED  = 2'd2
    } fq_state_e;

    function automatic logic is_halt(input logic [15:0] instr, input logic [3:0] opcode);
        return instr[15:12] == opcode;
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer of DEPTH entries with synchronous flush; a pop and a push in the
// same cycle both take effect (the head is read before the slot can be reused).
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one outstanding memory read at a time, results queued for decode.
// Define FETCH_QUEUE_BYPASS_EN to forward an ack straight to decode when the queue is empty.
//
// state      | meaning
// FQ_FETCH   | issuing / awaiting reads at fetch_pc
// FQ_DISCARD | a redirect orphaned an outstanding read; its data is dropped on ack
// FQ_HALTED  | HALT opcode enqueued; no fetches until the next redirect
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH       = FQ_DEPTH,
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = FQ_HALT_OPCODE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [15:0]            redirect_pc,
    output logic                   mem_req,
    output logic [15:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [15:0]            mem_rdata,
    output logic                   out_valid,
    output logic [15:0]            out_instr,
    output logic [15:0]            out_pc_plus1,
    input  logic                   out_ready,
    output logic                   hlt_seen,
    output logic [15:0]            fetch_pc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int             CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

    fq_state_e   state;
    logic [15:0] addr_plus1;
    logic        take;
    logic        push;
    logic        fifo_pop;
    logic        fifo_empty;
    logic [31:0] head;

    assign addr_plus1 = mem_addr + 16'd1;
    // An ack only carries usable data in FETCH and when no redirect is flushing this cycle.
    assign take = (state == FQ_FETCH) && mem_req && mem_ack && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass       = fifo_empty && take;
    assign out_valid    = !fifo_empty || bypass;
    assign out_instr    = bypass ? mem_rdata  : head[31:16];
    assign out_pc_plus1 = bypass ? addr_plus1 : head[15:0];
    assign push         = take && !(bypass && out_ready);
    assign fifo_pop     = !fifo_empty && out_ready;
`else
    assign out_valid    = !fifo_empty;
    assign out_instr    = head[31:16];
    assign out_pc_plus1 = head[15:0];
    assign push         = take;
    assign fifo_pop     = out_valid && out_ready;
`endif

    fq_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({mem_rdata, addr_plus1}),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FQ_FETCH;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            hlt_seen <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            hlt_seen <= 1'b0;
            // A request cannot be abandoned, so keep it up and swallow its eventual ack.
            if (mem_req && !mem_ack) begin
                state <= FQ_DISCARD;
            end else begin
                state   <= FQ_FETCH;
                mem_req <= 1'b0;
            end
        end else begin
            case (state)
                FQ_FETCH: begin
                    if (mem_req) begin
                        if (mem_ack) begin
                            mem_req  <= 1'b0;
                            fetch_pc <= addr_plus1;
                            if (is_halt(mem_rdata, HALT_OPCODE)) begin
                                hlt_seen <= 1'b1;
                                state    <= FQ_HALTED;
                            end
                        end
                    end else if (count < FULL_COUNT) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                FQ_DISCARD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= FQ_FETCH;
                    end
                end
                FQ_HALTED: mem_req <= 1'b0;
                default:   state   <= FQ_FETCH;
            endcase
        end
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues one read at a time to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned instructions, each with its PC+1, in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles redirects (taken branch/JAL/JR) by flushing, and stops fetching after a HLT opcode.

Parameters:
- DEPTH, 4, FIFO entries; power of two, range 2..16.
- RESET_PC, 16'h0000, first fetch address after reset.
- HALT_OPCODE, 4'hF, value of instr[15:12] that stops fetching.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  16  redirect target.
- mem_req  out  1  read request to instruction memory (registered).
- mem_addr  out  16  read address; stable while mem_req=1.
- mem_ack  in  1  request complete; mem_rdata valid this cycle; ignored when mem_req=0.
- mem_rdata  in  16  fetched instruction.
- out_valid  out  1  decode-side entry available.
- out_instr  out  16  head instruction.
- out_pc_plus1  out  16  head instruction address + 1.
- out_ready  in  1  decode accepts head; a pop occurs when out_valid && out_ready.
- hlt_seen  out  1  a HALT_OPCODE instruction has been enqueued.
- fetch_pc  out  16  address of the next/outstanding fetch.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst=1), applied immediately:
  - mem_req=0, out_valid=0, hlt_seen=0, count=0.
  - fetch_pc=RESET_PC, mem_addr=RESET_PC.
  - state=FETCH, FIFO pointers=0.
- States: FETCH, DISCARD, HALTED.
- FETCH:
  - When mem_req=0, count<DEPTH and no redirect, set mem_req=1 with mem_addr=fetch_pc on the next edge.
  - Hold mem_req/mem_addr until the cycle mem_ack=1. Only one request is ever outstanding.
  - On ack: enqueue {mem_rdata, mem_addr+1}; fetch_pc=mem_addr+1 (16-bit wrap, FFFF->0000); deassert mem_req for at least one cycle.
  - If the acked instr[15:12]==HALT_OPCODE: enqueue it, set hlt_seen=1, go to HALTED.
- HALTED: mem_req=0; FIFO continues to drain normally.
- Redirect (any state), same edge:
  - FIFO flushed; count=0; out_valid=0 from the next cycle.
  - fetch_pc=redirect_pc; hlt_seen=0.
  - If mem_req=1 and mem_ack=0 → DISCARD. mem_req/mem_addr stay held (the protocol forbids abandoning a request).
  - Otherwise → FETCH. An ack in the same cycle is dropped, and the new request issues on the following edge.
- DISCARD:
  - On ack, drop the data, deassert mem_req, go to FETCH.
  - A further redirect while in DISCARD only updates fetch_pc.
- Simultaneous pop + redirect: the pop is honoured (decode consumed it), then the flush applies.
- Simultaneous pop + enqueue when full: not possible, because a request is only issued when count<DEPTH.
- Out latency: ack at cycle N → out_valid at N+1 (empty queue).
- Ordering: strict FIFO. out_* come from the head entry, registered storage.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined: when the FIFO is empty, mem_ack=1, no redirect and state FETCH, out_valid/out_instr/out_pc_plus1 are driven combinationally from mem_rdata/mem_addr+1 in the ack cycle.
  - If out_ready=1 that cycle, the entry is not written.
  - The halt rule still applies.
- Undefined: there is no combinational mem→out path; minimum latency is one cycle.

Decomposition:
- Shared package fetch_pkg:
  - state encoding (FQ_FETCH, FQ_DISCARD, FQ_HALTED);
  - HALT_OPCODE default 4'hF;
  - DEPTH default 4.
- One sub-module fq_fifo:
  - parameterised DEPTH×32 circular buffer;
  - push, pop, synchronous flush, count;
  - pop-before-push semantics.

Test Plan:
- Reset release, memory acks 1 cycle after req, mem[0000]=16'h1234 → first mem_addr=0000; out_instr=1234, out_pc_plus1=0001 one cycle after ack.
- out_ready=0, DEPTH=4, mem[0..3]=16'h1000..1003 → count reaches 4 and mem_req stays 0; raise out_ready → pops 1000,1001,1002,1003 in order, fetch resumes at 0004.
- Request to 0005 outstanding, redirect_pc=0040, ack 3 cycles later with 16'hAAAA → AAAA never appears on out; next mem_addr=0040, count=0.
- mem[0007]=16'hF000 → enqueued, hlt_seen=1, mem_req stays 0 for 20 cycles; redirect to 0010 → hlt_seen=0, mem_addr=0010.
- RESET_PC=16'hFFFF → first out_pc_plus1=0000, second mem_addr=0000.
- rst asserted mid-DISCARD (not clock-aligned) → mem_req, out_valid, count go to 0 immediately; after release, the first fetch is at RESET_PC.
